// File: rtl/apb_ucpd_tx_sched.sv
// UCPD TX scheduler: arbitrates message and hard/cable reset sends and steps through the gap, line-idle and TX phases.
// Optional TX watchdog: define UCPD_TX_TIMEOUT_EN.
module apb_ucpd_tx_sched #(
    parameter int TO_W    = 10,
    parameter int TO_HBIT = 1023
) (
    input  logic ic_clk,
    input  logic ic_rst_n,
    input  logic tx_req,
    input  logic hrst_req,
    input  logic rx_busy,
    input  logic ifrgap_en,
    input  logic transwin_en,
    input  logic hbit_clk_red,
    input  logic tx_eop_cmplt,
    input  logic tx_sop_rst_cmplt,
    output logic wait_en,
    output logic bmc_en,
    output logic transmit_en,
    output logic tx_hrst,
    output logic tx_msg_sent,
    output logic tx_hrst_sent,
    output logic tx_msg_disc,
    output logic tx_msg_abt,
    output logic tx_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_LINE,
        ST_TX,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic   msg_pend_q, msg_pend_d;
    logic   hrst_pend_q, hrst_pend_d;
    logic   wait_en_q, wait_en_d;
    logic   bmc_en_q, bmc_en_d;
    logic   transmit_en_q, transmit_en_d;
    logic   tx_hrst_q, tx_hrst_d;
    logic   msg_sent_q, msg_sent_d;
    logic   hrst_sent_q, hrst_sent_d;
    logic   msg_disc_q, msg_disc_d;
    logic   msg_abt_q, msg_abt_d;
    logic   busy_q, busy_d;
    logic   preempt;
    logic   cmplt;

`ifdef UCPD_TX_TIMEOUT_EN
    localparam logic [TO_W-1:0] ToLimit = TO_W'(TO_HBIT);
    localparam logic [TO_W-1:0] ToLast  = TO_W'(TO_HBIT - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // A hard reset request only pre-empts when the transfer in flight is a message.
    assign preempt = !tx_hrst_q && hrst_req;
    assign cmplt   = tx_hrst_q ? tx_sop_rst_cmplt : tx_eop_cmplt;

    always_comb begin
        state_d       = state_q;
        msg_pend_d    = msg_pend_q | tx_req;
        hrst_pend_d   = hrst_pend_q | hrst_req;
        wait_en_d     = wait_en_q;
        bmc_en_d      = bmc_en_q;
        transmit_en_d = transmit_en_q;
        tx_hrst_d     = tx_hrst_q;
        msg_sent_d    = 1'b0;
        hrst_sent_d   = 1'b0;
        msg_disc_d    = 1'b0;
        msg_abt_d     = 1'b0;
`ifdef UCPD_TX_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hrst_pend_q || msg_pend_q) begin
                    state_d       = ST_GAP;
                    tx_hrst_d     = hrst_pend_q;
                    wait_en_d     = 1'b1;
                    bmc_en_d      = 1'b0;
                    transmit_en_d = 1'b0;
                end
            end
            ST_GAP, ST_LINE: begin
                if (preempt) begin
                    state_d    = ST_GAP;
                    msg_disc_d = 1'b1;
                    msg_pend_d = tx_req;
                    tx_hrst_d  = 1'b1;
                    wait_en_d  = 1'b1;
                    bmc_en_d   = 1'b0;
                end else if (state_q == ST_GAP) begin
                    if (ifrgap_en) begin
                        state_d   = ST_LINE;
                        wait_en_d = 1'b0;
                        bmc_en_d  = 1'b0;
                    end
                end else if (!tx_hrst_q && rx_busy) begin
                    state_d    = ST_IDLE;
                    msg_disc_d = 1'b1;
                    msg_pend_d = tx_req;
                    wait_en_d  = 1'b0;
                    bmc_en_d   = 1'b0;
                    tx_hrst_d  = 1'b0;
                end else if (transwin_en) begin
                    state_d       = ST_TX;
                    transmit_en_d = 1'b1;
                    bmc_en_d      = 1'b1;
`ifdef UCPD_TX_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
            end
            ST_TX: begin
                if (cmplt) begin
                    state_d       = ST_DONE;
                    transmit_en_d = 1'b0;
                    bmc_en_d      = 1'b0;
                    tx_hrst_d     = 1'b0;
                    if (tx_hrst_q) begin
                        hrst_sent_d = 1'b1;
                        hrst_pend_d = hrst_req;
                    end else begin
                        msg_sent_d = 1'b1;
                        msg_pend_d = tx_req;
                    end
                end else if (preempt) begin
                    state_d       = ST_GAP;
                    msg_abt_d     = 1'b1;
                    msg_pend_d    = tx_req;
                    tx_hrst_d     = 1'b1;
                    transmit_en_d = 1'b0;
                    bmc_en_d      = 1'b0;
                    wait_en_d     = 1'b1;
`ifdef UCPD_TX_TIMEOUT_EN
                end else if (hbit_clk_red) begin
                    if (to_cnt_q != ToLimit) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                    // The strobe that brings the count to the limit ends the transfer.
                    if (to_cnt_q == ToLast) begin
                        state_d       = ST_DONE;
                        transmit_en_d = 1'b0;
                        bmc_en_d      = 1'b0;
                        tx_hrst_d     = 1'b0;
                        if (tx_hrst_q) begin
                            hrst_pend_d = hrst_req;
                        end else begin
                            msg_abt_d  = 1'b1;
                            msg_pend_d = tx_req;
                        end
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q       <= ST_IDLE;
            msg_pend_q    <= 1'b0;
            hrst_pend_q   <= 1'b0;
            wait_en_q     <= 1'b0;
            bmc_en_q      <= 1'b0;
            transmit_en_q <= 1'b0;
            tx_hrst_q     <= 1'b0;
            msg_sent_q    <= 1'b0;
            hrst_sent_q   <= 1'b0;
            msg_disc_q    <= 1'b0;
            msg_abt_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UCPD_TX_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            msg_pend_q    <= msg_pend_d;
            hrst_pend_q   <= hrst_pend_d;
            wait_en_q     <= wait_en_d;
            bmc_en_q      <= bmc_en_d;
            transmit_en_q <= transmit_en_d;
            tx_hrst_q     <= tx_hrst_d;
            msg_sent_q    <= msg_sent_d;
            hrst_sent_q   <= hrst_sent_d;
            msg_disc_q    <= msg_disc_d;
            msg_abt_q     <= msg_abt_d;
            busy_q        <= busy_d;
`ifdef UCPD_TX_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign wait_en      = wait_en_q;
    assign bmc_en       = bmc_en_q;
    assign transmit_en  = transmit_en_q;
    assign tx_hrst      = tx_hrst_q;
    assign tx_msg_sent  = msg_sent_q;
    assign tx_hrst_sent = hrst_sent_q;
    assign tx_msg_disc  = msg_disc_q;
    assign tx_msg_abt   = msg_abt_q;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed self-checking bench for apb_ucpd_tx_sched; watchdog expectations follow UCPD_TX_TIMEOUT_EN.
module tb_apb_ucpd_tx_sched;

    localparam logic [6:0] P_TX   = 7'b1000000;
    localparam logic [6:0] P_HRST = 7'b0100000;
    localparam logic [6:0] P_GAP  = 7'b0010000;
    localparam logic [6:0] P_WIN  = 7'b0001000;
    localparam logic [6:0] P_HBIT = 7'b0000100;
    localparam logic [6:0] P_EOP  = 7'b0000010;
    localparam logic [6:0] P_SOP  = 7'b0000001;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic txReq = 1'b0, hrstReq = 1'b0, rxBusy = 1'b0, ifrgapEn = 1'b0, transwinEn = 1'b0;
    logic hbitClkRed = 1'b0, txEopCmplt = 1'b0, txSopRstCmplt = 1'b0;
    logic waitEn, bmcEn, transmitEn, txHrst;
    logic txMsgSent, txHrstSent, txMsgDisc, txMsgAbt, txBusy;
    int   compared = 0;
    int   mismatched = 0;

    apb_ucpd_tx_sched #(.TO_W(10), .TO_HBIT(16)) dut (
        .ic_clk          (clk),
        .ic_rst_n        (rstN),
        .tx_req          (txReq),
        .hrst_req        (hrstReq),
        .rx_busy         (rxBusy),
        .ifrgap_en       (ifrgapEn),
        .transwin_en     (transwinEn),
        .hbit_clk_red    (hbitClkRed),
        .tx_eop_cmplt    (txEopCmplt),
        .tx_sop_rst_cmplt(txSopRstCmplt),
        .wait_en         (waitEn),
        .bmc_en          (bmcEn),
        .transmit_en     (transmitEn),
        .tx_hrst         (txHrst),
        .tx_msg_sent     (txMsgSent),
        .tx_hrst_sent    (txHrstSent),
        .tx_msg_disc     (txMsgDisc),
        .tx_msg_abt      (txMsgAbt),
        .tx_busy         (txBusy)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive order {wait_en, bmc_en, transmit_en, tx_hrst}.
    task automatic checkDrive(input string tag, input logic [3:0] expected);
        checkOutput(tag, {28'd0, waitEn, bmcEn, transmitEn, txHrst}, {28'd0, expected});
    endtask

    // Status order {tx_msg_sent, tx_hrst_sent, tx_msg_disc, tx_msg_abt, tx_busy}.
    task automatic checkStatus(input string tag, input logic [4:0] expected);
        checkOutput(tag, {27'd0, txMsgSent, txHrstSent, txMsgDisc, txMsgAbt, txBusy}, {27'd0, expected});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the selected strobes for exactly one clock, then sample just after the edge.
    task automatic applyStimulus(input logic [6:0] mask);
        {txReq, hrstReq, ifrgapEn, transwinEn, hbitClkRed, txEopCmplt, txSopRstCmplt} = mask;
        idleCycles(1);
        {txReq, hrstReq, ifrgapEn, transwinEn, hbitClkRed, txEopCmplt, txSopRstCmplt} = 7'b0;
    endtask

    task automatic startMsgToTx();
        applyStimulus(P_TX);
        idleCycles(1);
        applyStimulus(P_GAP);
        applyStimulus(P_WIN);
    endtask

    initial begin
        idleCycles(2);
        checkDrive("reset_drive", 4'b0000);
        checkStatus("reset_status", 5'b00000);
        rstN = 1'b1;
        idleCycles(2);
        checkStatus("idle_after_reset", 5'b00000);

        $display("[TB] basic message send");
        applyStimulus(P_TX);
        checkStatus("msg_latched_idle", 5'b00000);
        idleCycles(1);
        checkDrive("msg_gap_drive", 4'b1000);
        checkStatus("msg_gap_busy", 5'b00001);
        idleCycles(4);
        applyStimulus(P_GAP);
        checkDrive("msg_line_drive", 4'b0000);
        idleCycles(7);
        applyStimulus(P_WIN);
        checkDrive("msg_tx_drive", 4'b0110);
        idleCycles(39);
        checkDrive("msg_tx_hold", 4'b0110);
        applyStimulus(P_EOP);
        checkDrive("msg_done_drive", 4'b0000);
        checkStatus("msg_sent_pulse", 5'b10001);
        idleCycles(1);
        checkStatus("msg_back_idle", 5'b00000);

        $display("[TB] simultaneous message and hard reset");
        applyStimulus(P_TX | P_HRST);
        idleCycles(1);
        checkDrive("both_gap_hrst", 4'b1001);
        applyStimulus(P_GAP);
        checkDrive("both_line_hrst", 4'b0001);
        rxBusy = 1'b1;
        applyStimulus(P_WIN);
        rxBusy = 1'b0;
        checkDrive("hrst_ignores_rxbusy", 4'b0111);
        applyStimulus(P_EOP);
        checkDrive("hrst_wrong_cmplt_drive", 4'b0111);
        checkStatus("hrst_wrong_cmplt_status", 5'b00001);
        applyStimulus(P_SOP);
        checkDrive("hrst_done_drive", 4'b0000);
        checkStatus("hrst_sent_pulse", 5'b01001);
        idleCycles(1);
        checkStatus("hrst_idle_between", 5'b00000);
        idleCycles(1);
        checkDrive("queued_msg_gap", 4'b1000);
        applyStimulus(P_GAP);
        applyStimulus(P_WIN);
        checkDrive("queued_msg_tx", 4'b0110);
        applyStimulus(P_EOP);
        checkStatus("queued_msg_sent", 5'b10001);
        idleCycles(1);

        $display("[TB] line busy discard");
        applyStimulus(P_TX);
        idleCycles(1);
        applyStimulus(P_GAP);
        rxBusy = 1'b1;
        idleCycles(1);
        rxBusy = 1'b0;
        checkStatus("disc_pulse", 5'b00100);
        checkDrive("disc_drive", 4'b0000);
        idleCycles(1);
        checkStatus("disc_one_cycle", 5'b00000);
        idleCycles(3);
        checkStatus("disc_stays_idle", 5'b00000);

        $display("[TB] hard reset aborts message in TX");
        startMsgToTx();
        idleCycles(10);
        applyStimulus(P_HRST);
        checkDrive("abort_gap_drive", 4'b1001);
        checkStatus("abort_pulse", 5'b00011);
        idleCycles(1);
        checkStatus("abort_one_cycle", 5'b00001);
        applyStimulus(P_GAP);
        applyStimulus(P_WIN);
        checkDrive("abort_hrst_tx", 4'b0111);
        applyStimulus(P_SOP);
        checkStatus("abort_hrst_sent", 5'b01001);
        idleCycles(2);
        checkStatus("abort_msg_dropped", 5'b00000);

        $display("[TB] hard reset pre-empts message in GAP");
        applyStimulus(P_TX);
        idleCycles(1);
        applyStimulus(P_HRST);
        checkDrive("preempt_gap_drive", 4'b1001);
        checkStatus("preempt_disc", 5'b00101);
        applyStimulus(P_GAP);
        applyStimulus(P_WIN);
        applyStimulus(P_SOP);
        checkStatus("preempt_hrst_sent", 5'b01001);
        idleCycles(2);
        checkStatus("preempt_idle", 5'b00000);

        $display("[TB] watchdog");
        startMsgToTx();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(P_HBIT);
            idleCycles(1);
        end
        checkDrive("wdog_before_limit", 4'b0110);
        checkStatus("wdog_before_limit_st", 5'b00001);
        applyStimulus(P_HBIT);
`ifdef UCPD_TX_TIMEOUT_EN
        checkDrive("wdog_abort_drive", 4'b0000);
        checkStatus("wdog_abort_pulse", 5'b00011);
        idleCycles(1);
        checkStatus("wdog_idle", 5'b00000);
`else
        checkDrive("no_wdog_stays_tx", 4'b0110);
        checkStatus("no_wdog_no_abort", 5'b00001);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(P_HBIT);
        end
        checkDrive("no_wdog_still_tx", 4'b0110);
        applyStimulus(P_EOP);
        checkStatus("no_wdog_sent", 5'b10001);
        idleCycles(1);
`endif

        $display("[TB] request coincident with completion");
        startMsgToTx();
        applyStimulus(P_EOP | P_TX);
        checkStatus("coinc_sent", 5'b10001);
        idleCycles(1);
        checkStatus("coinc_idle", 5'b00000);
        idleCycles(1);
        checkDrive("coinc_new_gap", 4'b1000);
        applyStimulus(P_GAP);
        rxBusy = 1'b1;
        idleCycles(1);
        rxBusy = 1'b0;
        checkStatus("coinc_disc", 5'b00100);

        $display("[TB] async reset during TX");
        startMsgToTx();
        applyStimulus(P_TX);
        idleCycles(2);
        #2 rstN = 1'b0;
        #1;
        checkDrive("async_rst_drive", 4'b0000);
        checkStatus("async_rst_status", 5'b00000);
        idleCycles(2);
        rstN = 1'b1;
        idleCycles(5);
        checkDrive("post_rst_drive", 4'b0000);
        checkStatus("post_rst_status", 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
